// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Operands are reduced to magnitudes; sign correction is applied in a dedicated FIX cycle.
module mips_muldiv_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 3,
    parameter int NB_CNT  = 6
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic               i_cancel,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                 r_state;
    logic [NB_CNT-1:0]      r_cnt;
    logic [2*NB_DATA-1:0]   r_acc;
    logic [NB_DATA-1:0]     r_b;
    logic [NB_DATA-1:0]     r_hi;
    logic [NB_DATA-1:0]     r_lo;
    logic                   r_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_sa;
    logic                   w_sb;
    logic [NB_DATA:0]       w_msum;
    logic [NB_DATA:0]       w_dsh;
    logic [NB_DATA+1:0]     w_dtry;
    logic [2*NB_DATA-1:0]   w_step;
    logic [2*NB_DATA-1:0]   w_prod;
    logic [NB_DATA-1:0]     w_q;
    logic [NB_DATA-1:0]     w_r;
    logic [NB_DATA-1:0]     w_hi;
    logic [NB_DATA-1:0]     w_lo;

    assign w_sa = !i_op[0] && i_rs_data[NB_DATA-1];
    assign w_sb = !i_op[0] && i_rt_data[NB_DATA-1];

    // Accumulator upper half is the partial product / remainder, lower half the multiplier / dividend-quotient
    assign w_msum = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_dsh  = r_acc[2*NB_DATA-1:NB_DATA-1];
    assign w_dtry = {1'b0, w_dsh} - {2'b0, r_b};
    assign w_step = !r_div ? {w_msum, r_acc[NB_DATA-1:1]} :
                    w_dtry[NB_DATA+1] ? {w_dsh[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0} :
                                        {w_dtry[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_q    = r_neg_q ? -r_acc[NB_DATA-1:0] : r_acc[NB_DATA-1:0];
    assign w_r    = r_neg_r ? -r_acc[2*NB_DATA-1:NB_DATA] : r_acc[2*NB_DATA-1:NB_DATA];
    // Divide by zero leaves |rs| as remainder naturally; only the quotient needs forcing
    assign w_hi   = r_div ? w_r : w_prod[2*NB_DATA-1:NB_DATA];
    assign w_lo   = r_div ? ((r_b == '0) ? '1 : w_q) : w_prod[NB_DATA-1:0];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (i_start && !i_cancel) begin
                        if (!i_op[2]) begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_div   <= i_op[1];
                            r_neg_q <= w_sa ^ w_sb;
                            r_neg_r <= w_sa;
                            r_acc   <= {{NB_DATA{1'b0}}, w_sa ? -i_rs_data : i_rs_data};
                            r_b     <= w_sb ? -i_rt_data : i_rt_data;
                        end else if (!i_op[1]) begin
                            if (i_op[0]) r_lo <= i_rs_data;
                            else         r_hi <= i_rs_data;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (i_cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + NB_CNT'(1);
                        if (r_cnt == NB_CNT'(NB_DATA-1)) r_state <= FIX;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    if (i_cancel) begin
                        r_state <= IDLE;
                    end else begin
                        r_hi    <= w_hi;
                        r_lo    <= w_lo;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule
